input_buffer: RTL and testbench
===============================

INPUT_BUFFER -- requirements
Module: input_buffer

Interface
REQ-001 SHALL have parameter: DATA_WIDTH, default 8, word width and number of serial bits per word (>=2).
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: sensor_data  input  1  serial data bit, sampled on every rising clk while reset low.
REQ-005 SHALL have port: data_processed  input  1  consumer acknowledge of the current word.
REQ-006 SHALL have port: data_output  output  DATA_WIDTH  last completed word, registered.
REQ-007 SHALL have port: data_ready  output  1  registered; high while an unacknowledged word is held.
REQ-008 SHALL have, only when INPUT_BUFFER_OVERRUN_EN is defined, port: overrun  output  1  sticky lost-word flag.

Function
REQ-009 SHALL sample sensor_data on every rising clk with reset low; framing is free-running from reset release; no start/stop bits.
REQ-010 SHALL assemble words MSB-first: first sampled bit lands in data_output[DATA_WIDTH-1], last sampled bit in bit 0.
REQ-011 SHALL keep a bit counter 0..DATA_WIDTH-1; it increments per sample and wraps to 0 on the DATA_WIDTH-th sample.
REQ-012 SHALL, on the edge sampling the DATA_WIDTH-th bit, load the complete word (including that bit) into data_output and set data_ready; both are visible immediately after that edge (zero extra latency).
REQ-013 SHALL hold data_output stable between word completions.
REQ-014 SHALL clear data_ready on a rising edge where data_processed is high, unless a word completes on that same edge.
REQ-015 SHALL, when a word completes on the same edge as data_processed is high, load the new word and keep data_ready high (completion wins; no overrun).
REQ-016 SHALL ignore data_processed while data_ready is low.
REQ-017 SHALL continue shifting regardless of data_ready; a word completing while data_ready is high and unacknowledged overwrites data_output and data_ready stays high.
REQ-018 SHALL not stall or drop serial bits under any handshake condition.

Reset
REQ-019 SHALL, while reset is high, immediately (asynchronously) force shift register to 0, bit counter to 0, data_output to 0, data_ready to 0, overrun to 0.
REQ-020 SHALL discard any partial word on reset mid-operation; the first sample after reset release is bit DATA_WIDTH-1 of a new word.

Configuration
REQ-021 SHALL, with macro INPUT_BUFFER_OVERRUN_EN defined, provide overrun: set on a word completion while data_ready is high and data_processed is low; cleared on an edge where data_processed is high and no overrun condition occurs that edge.
REQ-022 SHALL, without INPUT_BUFFER_OVERRUN_EN, omit the overrun port and logic entirely; all other behaviour identical.

Verification
REQ-023 SHALL cover: reset pulse, then bits 1,1,0,1,0,1,0,1 on 8 consecutive edges -> after 8th edge data_output=0xD5, data_ready=1; data_ready=0 before 8th edge.
REQ-024 SHALL cover: data_processed high for one edge after 0xD5 -> data_ready=0 after that edge, data_output stays 0xD5.
REQ-025 SHALL cover: 3 bits of 0x33 (0,0,1) sent, then reset pulse -> data_output=0, data_ready=0; then 8 bits of 0xAA -> data_output=0xAA, data_ready=1 after 8th edge.
REQ-026 SHALL cover: 0xF0 then 0x0F with no acknowledge -> data_output=0x0F, data_ready=1; with INPUT_BUFFER_OVERRUN_EN overrun=1 after 16th edge, cleared by one data_processed edge.
REQ-027 SHALL cover: data_processed high on the completing edge of a second word 0x3C -> data_output=0x3C, data_ready=1, overrun=0.
REQ-028 SHALL cover: reset asserted asynchronously between clock edges -> all outputs 0 before the next rising clk.

Source files
------------

// File: rtl/input_buffer.sv
// input_buffer: serial-to-parallel receiver with a one-word holding register and a
// ready/acknowledge handshake.
//
// Bits on sensor_data are sampled on every rising clk while reset is low. Framing is
// free-running from reset release, with no start or stop bits. Words are assembled
// MSB-first. On the edge that samples the last bit of a word, the complete word goes to
// data_output and data_ready is raised. Shifting never stalls. A new word overwrites an
// unacknowledged one.
//
// Optional feature: define INPUT_BUFFER_OVERRUN_EN to add the sticky overrun flag.
//
// Ports:
//   clk            in   clock, all state changes on the rising edge
//   reset          in   asynchronous active-high reset
//   sensor_data    in   serial data bit
//   data_processed in   consumer acknowledge of the held word
//   data_output    out  [DATA_WIDTH-1:0] last completed word (registered)
//   data_ready     out  high while an unacknowledged word is held (registered)
//   overrun        out  sticky lost-word flag (only with INPUT_BUFFER_OVERRUN_EN)
module input_buffer #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sensor_data,
  input  logic                  data_processed,
  output logic [DATA_WIDTH-1:0] data_output,
  output logic                  data_ready
`ifdef INPUT_BUFFER_OVERRUN_EN
  ,
  output logic                  overrun
`endif
);

  localparam int unsigned CntW = $clog2(DATA_WIDTH);

  // Only DATA_WIDTH-1 earlier bits are needed. The final bit comes straight from
  // sensor_data on the completing edge.
  logic [DATA_WIDTH-2:0] shift_q, shift_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_output_q, data_output_d;
  logic                  data_ready_q, data_ready_d;
  logic                  word_done;

  always_comb begin
    word_done = (cnt_q == CntW'(DATA_WIDTH - 1));

    shift_d[0] = sensor_data;
    for (int i = 1; i < DATA_WIDTH - 1; i++) begin
      shift_d[i] = shift_q[i-1];
    end

    cnt_d         = word_done ? '0 : cnt_q + CntW'(1);
    data_output_d = word_done ? {shift_q, sensor_data} : data_output_q;

    // Completion wins over acknowledge. An acknowledge while not ready is a no-op.
    data_ready_d = data_ready_q;
    if (word_done) begin
      data_ready_d = 1'b1;
    end else if (data_processed) begin
      data_ready_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q       <= '0;
      cnt_q         <= '0;
      data_output_q <= '0;
      data_ready_q  <= 1'b0;
    end else begin
      shift_q       <= shift_d;
      cnt_q         <= cnt_d;
      data_output_q <= data_output_d;
      data_ready_q  <= data_ready_d;
    end
  end

  assign data_output = data_output_q;
  assign data_ready  = data_ready_q;

`ifdef INPUT_BUFFER_OVERRUN_EN
  logic overrun_q, overrun_d;

  // A word is lost when a new one lands on top of an unacknowledged one.
  always_comb begin
    overrun_d = overrun_q;
    if (word_done && data_ready_q && !data_processed) begin
      overrun_d = 1'b1;
    end else if (data_processed) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= overrun_d;
    end
  end

  assign overrun = overrun_q;
`endif

endmodule

// File: tb/tb_input_buffer.sv
// tb_input_buffer: directed self-checking bench for input_buffer (DATA_WIDTH = 8).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// Overrun checks are compiled in only when INPUT_BUFFER_OVERRUN_EN is defined.
module tb_input_buffer;

  logic       clk = 1'b0;
  logic       reset;
  logic       sensor_data;
  logic       data_processed;
  logic [7:0] data_output;
  logic       data_ready;
`ifdef INPUT_BUFFER_OVERRUN_EN
  logic       overrun;
`endif

  int n_checks = 0;
  int n_errors = 0;

  input_buffer #(
    .DATA_WIDTH(8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .sensor_data   (sensor_data),
    .data_processed(data_processed),
    .data_output   (data_output),
    .data_ready    (data_ready)
`ifdef INPUT_BUFFER_OVERRUN_EN
    ,
    .overrun       (overrun)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one serial bit (and optional acknowledge) across one rising edge.
  task automatic step(input logic b, input logic ack);
    sensor_data    = b;
    data_processed = ack;
    @(posedge clk);
    #1;
    sensor_data    = 1'b0;
    data_processed = 1'b0;
  endtask

  // Send a full word MSB-first. Acknowledge is asserted on bit index ack_idx (0 = first
  // edge). A value of -1 means no acknowledge.
  task automatic send_word(input logic [7:0] w, input int ack_idx);
    for (int i = 0; i < 8; i++) begin
      step(w[7-i], (i == ack_idx));
    end
  endtask

  initial begin
    logic [7:0] w;
    reset          = 1'b1;
    sensor_data    = 1'b0;
    data_processed = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_value("reset_data", {24'd0, data_output}, 32'h00);
    check_value("reset_ready", {31'd0, data_ready}, 32'd0);
`ifdef INPUT_BUFFER_OVERRUN_EN
    check_value("reset_overrun", {31'd0, overrun}, 32'd0);
`endif
    reset = 1'b0;

    // First word 0xD5. data_ready must stay low until the 8th edge.
    w = 8'hD5;
    for (int i = 0; i < 8; i++) begin
      step(w[7-i], 1'b0);
      if (i < 7) check_value("d5_ready_early", {31'd0, data_ready}, 32'd0);
    end
    check_value("d5_data", {24'd0, data_output}, 32'hD5);
    check_value("d5_ready", {31'd0, data_ready}, 32'd1);

    // Acknowledge on the first bit of 0x33. The held word must stay stable.
    step(1'b0, 1'b1);
    check_value("ack_ready", {31'd0, data_ready}, 32'd0);
    check_value("ack_data_hold", {24'd0, data_output}, 32'hD5);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    check_value("partial_data_hold", {24'd0, data_output}, 32'hD5);

    // Asynchronous reset between edges discards the partial word.
    #1 reset = 1'b1;
    #1;
    check_value("async_rst_data", {24'd0, data_output}, 32'h00);
    check_value("async_rst_ready", {31'd0, data_ready}, 32'd0);
`ifdef INPUT_BUFFER_OVERRUN_EN
    check_value("async_rst_overrun", {31'd0, overrun}, 32'd0);
`endif
    #1 reset = 1'b0;

    // 0xAA framed from reset release.
    w = 8'hAA;
    for (int i = 0; i < 8; i++) begin
      step(w[7-i], 1'b0);
      if (i == 6) check_value("aa_ready_early", {31'd0, data_ready}, 32'd0);
    end
    check_value("aa_data", {24'd0, data_output}, 32'hAA);
    check_value("aa_ready", {31'd0, data_ready}, 32'd1);

    // 0xF0 with 0xAA acknowledged on its first bit, then 0x0F unacknowledged.
    send_word(8'hF0, 0);
    check_value("f0_data", {24'd0, data_output}, 32'hF0);
    check_value("f0_ready", {31'd0, data_ready}, 32'd1);
`ifdef INPUT_BUFFER_OVERRUN_EN
    check_value("f0_overrun", {31'd0, overrun}, 32'd0);
`endif
    send_word(8'h0F, -1);
    check_value("0f_data", {24'd0, data_output}, 32'h0F);
    check_value("0f_ready", {31'd0, data_ready}, 32'd1);
`ifdef INPUT_BUFFER_OVERRUN_EN
    check_value("0f_overrun", {31'd0, overrun}, 32'd1);
`endif

    // One acknowledge edge (first bit of 0x3C) clears ready and overrun.
    step(1'b0, 1'b1);
    check_value("ack2_ready", {31'd0, data_ready}, 32'd0);
    check_value("ack2_data", {24'd0, data_output}, 32'h0F);
`ifdef INPUT_BUFFER_OVERRUN_EN
    check_value("ack2_overrun", {31'd0, overrun}, 32'd0);
`endif
    // Rest of 0x3C, with an acknowledge on the completing edge.
    w = 8'h3C;
    for (int i = 1; i < 8; i++) begin
      step(w[7-i], (i == 7));
    end
    check_value("3c_data", {24'd0, data_output}, 32'h3C);
    check_value("3c_ready", {31'd0, data_ready}, 32'd1);
`ifdef INPUT_BUFFER_OVERRUN_EN
    check_value("3c_overrun", {31'd0, overrun}, 32'd0);
`endif

    // 0x81 overwrites the unacknowledged 0x3C and raises overrun. 0x5A then completes on
    // an acknowledge edge while ready is high: completion wins and overrun clears.
    send_word(8'h81, -1);
    check_value("81_data", {24'd0, data_output}, 32'h81);
`ifdef INPUT_BUFFER_OVERRUN_EN
    check_value("81_overrun", {31'd0, overrun}, 32'd1);
`endif
    send_word(8'h5A, 7);
    check_value("5a_data", {24'd0, data_output}, 32'h5A);
    check_value("5a_ready", {31'd0, data_ready}, 32'd1);
`ifdef INPUT_BUFFER_OVERRUN_EN
    check_value("5a_overrun", {31'd0, overrun}, 32'd0);
`endif

    // A plain acknowledge clears ready and leaves the word in place.
    step(1'b1, 1'b1);
    check_value("ack3_ready", {31'd0, data_ready}, 32'd0);
    check_value("ack3_data", {24'd0, data_output}, 32'h5A);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
